// File: rtl/xbar_control_issuer.sv
// xbar_control_issuer
// Initiator side of the crossbar control interface. Compact route requests
// {block, in_sel, out_sel} are queued in a small FIFO. Each request is expanded
// into a full crossbar control word and driven out over a val/rdy handshake.
//
// Build option: define XBAR_ISSUER_ECHO_CHECK_EN to confirm every write against
// the crossbar's registered echo (out_control). The echo is retried on timeout,
// and a sticky err is raised when the retries run out. Without the macro, a
// request completes on its handshake, err is tied low and echo_msg is ignored.
//
// Handshake rules for both the req_* and ctrl_* ports:
// - A transfer happens on a rising clk edge where valid && ready.
// - Once raised, valid and its payload stay stable until that transfer.
// - ready may change freely and is not a function of valid.

module xbar_control_issuer #(
    parameter int CONTROL_BIT_WIDTH = 42,
    parameter int ADDRESS_BIT_WIDTH = 4,
    parameter int WRITE_BIT_WIDTH   = 1,
    parameter int N_INPUTS          = 2,
    parameter int N_OUTPUTS         = 2,
    parameter int FIFO_DEPTH        = 4,
    parameter int ECHO_TIMEOUT      = 8,
    parameter int MAX_RETRY         = 2
) (
    input  logic                                                               clk,
    input  logic                                                               reset,
    input  logic [ADDRESS_BIT_WIDTH+$clog2(N_INPUTS)+$clog2(N_OUTPUTS)-1:0]    req_msg,
    input  logic                                                               req_val,
    output logic                                                               req_rdy,
    output logic [CONTROL_BIT_WIDTH-1:0]                                       ctrl_msg,
    output logic                                                               ctrl_val,
    input  logic                                                               ctrl_rdy,
    input  logic [CONTROL_BIT_WIDTH-1:0]                                       echo_msg,
    output logic                                                               done,
    output logic                                                               busy,
    output logic                                                               err,
    input  logic                                                               err_clr
);

    localparam int CBW   = CONTROL_BIT_WIDTH;
    localparam int A     = ADDRESS_BIT_WIDTH;
    localparam int WB    = WRITE_BIT_WIDTH;
    localparam int SI    = $clog2(N_INPUTS);
    localparam int SO    = $clog2(N_OUTPUTS);
    localparam int MSG_W = A + SI + SO;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_n;

    // Request FIFO: raw compact requests; expansion happens at the head.
    logic [MSG_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             rdy_en;

    logic [MSG_W-1:0] head_msg;
    logic [CBW-1:0]   packed_word;
    logic [CBW-1:0]   word_r;

`ifdef XBAR_ISSUER_ECHO_CHECK_EN
    localparam int TIMER_W = (ECHO_TIMEOUT > 1) ? $clog2(ECHO_TIMEOUT) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [TIMER_W-1:0] timer_r;
    logic [RETRY_W-1:0] retry_r;
    logic               echo_match;
    logic               timer_expired;
    logic               retry_inc;
    logic               err_set;
    logic               err_r;
`endif

    // ------------------------------------------------------------------
    // FIFO status and request-side handshake
    // ------------------------------------------------------------------
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

    // rdy_en keeps req_rdy low through reset and for the release edge itself.
    // Because req_rdy is low when full, a pop in the same cycle cannot make
    // room for a new entry.
    assign req_rdy = rdy_en && !fifo_full;
    assign push    = req_val && req_rdy;

    // Ready enable: rises on the first clock edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    // FIFO storage: payload only, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= req_msg;
        end
    end

    // FIFO pointers and occupancy. The depth is a power of two, so the
    // pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control word packing
    // ------------------------------------------------------------------
    assign head_msg = fifo_mem[rd_ptr];

    // Expand the head request into the control word, MSB to LSB:
    // block, write field (all ones), in_sel, out_sel, then zeros.
    always_comb begin
        packed_word = '0;
        packed_word[CBW-1 -: A]           = head_msg[SO+SI +: A];
        packed_word[CBW-A-1 -: WB]        = '1;
        packed_word[CBW-A-WB-1 -: SI]     = head_msg[SO +: SI];
        packed_word[CBW-A-WB-SI-1 -: SO]  = head_msg[0 +: SO];
    end

    // In-flight word register, loaded when the head is popped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_r <= '0;
        end else if (pop) begin
            word_r <= packed_word;
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next state, FIFO pop, and retry and error events.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
`ifdef XBAR_ISSUER_ECHO_CHECK_EN
        retry_inc = 1'b0;
        err_set   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ctrl_rdy) begin
`ifdef XBAR_ISSUER_ECHO_CHECK_EN
                    state_n = ST_WAIT;
`else
                    state_n = ST_DONE;
`endif
                end
            end
`ifdef XBAR_ISSUER_ECHO_CHECK_EN
            ST_WAIT: begin
                // A matching echo takes priority, even in the timeout cycle.
                if (echo_match) begin
                    state_n = ST_DONE;
                end else if (timer_expired) begin
                    if (retry_r < RETRY_W'(MAX_RETRY)) begin
                        retry_inc = 1'b1;
                        state_n   = ST_SEND;
                    end else begin
                        err_set = 1'b1;
                        state_n = ST_DONE;
                    end
                end
            end
`endif
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Control outputs. The word is driven only in SEND, so a stale echo of a
    // previous word cannot match a newly loaded one.
    assign ctrl_val = (state == ST_SEND);
    assign ctrl_msg = (state == ST_SEND) ? word_r : '0;
    assign done     = (state == ST_DONE);
    assign busy     = (state != ST_IDLE) || !fifo_empty;

`ifdef XBAR_ISSUER_ECHO_CHECK_EN
    // ------------------------------------------------------------------
    // Echo confirmation: timer, retry count, sticky error
    // ------------------------------------------------------------------
    assign echo_match    = (echo_msg == word_r);
    assign timer_expired = (timer_r == TIMER_W'(ECHO_TIMEOUT - 1));

    // Echo wait timer: zeroed while sending, counts every WAIT cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_r <= '0;
        end else if (state == ST_SEND) begin
            timer_r <= '0;
        end else if (state == ST_WAIT) begin
            timer_r <= timer_r + TIMER_W'(1);
        end
    end

    // Resend counter: cleared per request, counts timeouts that lead to a resend.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retry_r <= '0;
        end else if (pop) begin
            retry_r <= '0;
        end else if (retry_inc) begin
            retry_r <= retry_r + RETRY_W'(1);
        end
    end

    // Sticky error. If a set event and err_clr occur in the same cycle, the set wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_r <= 1'b0;
        end else if (err_set) begin
            err_r <= 1'b1;
        end else if (err_clr) begin
            err_r <= 1'b0;
        end
    end

    assign err = err_r;
`else
    // Without echo checking there is nothing that can fail.
    localparam int unused_echo_cfg = ECHO_TIMEOUT + MAX_RETRY;
    logic unused_echo_inputs;

    assign err                = 1'b0;
    assign unused_echo_inputs = ^{echo_msg, err_clr};
`endif

endmodule

// File: tb/tb_xbar_control_issuer.sv
// Testbench for xbar_control_issuer.
// A behavioural reference model, advanced every clock, predicts each output
// from the request queue and the issue rules. The DUT is compared with the
// model on every falling edge. Directed scenarios run first, then random
// traffic.

module tb_xbar_control_issuer;

    localparam int CBW   = 42;
    localparam int A     = 4;
    localparam int MW    = 6;
    localparam int DEPTH = 4;
    localparam int TO    = 8;
    localparam int MAXR  = 2;
`ifdef XBAR_ISSUER_ECHO_CHECK_EN
    localparam bit ECHO_EN = 1'b1;
`else
    localparam bit ECHO_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [MW-1:0]  req_msg;
    logic           req_val;
    logic           req_rdy;
    logic [CBW-1:0] ctrl_msg;
    logic           ctrl_val;
    logic           ctrl_rdy;
    logic [CBW-1:0] echo_msg;
    logic           done;
    logic           busy;
    logic           err;
    logic           err_clr;

    always #5 clk = ~clk;

    xbar_control_issuer dut (
        .clk      (clk),
        .reset    (reset),
        .req_msg  (req_msg),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .ctrl_msg (ctrl_msg),
        .ctrl_val (ctrl_val),
        .ctrl_rdy (ctrl_rdy),
        .echo_msg (echo_msg),
        .done     (done),
        .busy     (busy),
        .err      (err),
        .err_clr  (err_clr)
    );

    // ------------------------------------------------------------------
    // Reference model
    // phase: 0 waiting for work, 1 offering the word, 2 awaiting echo,
    //        3 completion pulse
    // ------------------------------------------------------------------
    logic [CBW-1:0] exp_q[$];
    int             m_phase = 0;
    logic [CBW-1:0] m_word = '0;
    int             m_timer = 0;
    int             m_retry = 0;
    bit             m_err = 1'b0;
    bit             m_rdy_en = 1'b0;
    bit             m_push;
    bit             m_set_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Control word from the compact request, built with plain arithmetic.
    function automatic logic [CBW-1:0] pack(input logic [MW-1:0] m);
        logic [CBW-1:0] w;
        int blk;
        int isel;
        int osel;
        blk  = int'(m) / 4;
        isel = (int'(m) / 2) % 2;
        osel = int'(m) % 2;
        w = '0;
        w = w | (CBW'(blk) << (CBW - A));
        w = w | (CBW'(1) << (CBW - A - 1));
        w = w | (CBW'(isel) << (CBW - A - 2));
        w = w | (CBW'(osel) << (CBW - A - 3));
        return w;
    endfunction

    // Model update, using the inputs the bench drove for this edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            m_phase  = 0;
            m_word   = '0;
            m_timer  = 0;
            m_retry  = 0;
            m_err    = 1'b0;
            m_rdy_en = 1'b0;
        end else begin
            m_push    = req_val && m_rdy_en && (exp_q.size() < DEPTH);
            m_set_err = 1'b0;
            case (m_phase)
                0: if (exp_q.size() > 0) begin
                    m_word  = exp_q.pop_front();
                    m_retry = 0;
                    m_phase = 1;
                end
                1: if (ctrl_rdy) begin
                    m_timer = 0;
                    m_phase = ECHO_EN ? 2 : 3;
                end
                2: begin
                    if (echo_msg == m_word) begin
                        m_phase = 3;
                    end else if (m_timer == TO - 1) begin
                        if (m_retry < MAXR) begin
                            m_retry = m_retry + 1;
                            m_phase = 1;
                        end else begin
                            m_set_err = 1'b1;
                            m_phase   = 3;
                        end
                    end else begin
                        m_timer = m_timer + 1;
                    end
                end
                default: m_phase = 0;
            endcase
            if (m_push) exp_q.push_back(pack(req_msg));
            if (m_set_err) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            m_rdy_en = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_outputs();
        logic [CBW-1:0] e_msg;
        e_msg = (m_phase == 1) ? m_word : '0;
        check("req_rdy",  64'(req_rdy),  64'(m_rdy_en && (exp_q.size() < DEPTH)));
        check("ctrl_val", 64'(ctrl_val), 64'(m_phase == 1));
        check("ctrl_msg", 64'(ctrl_msg), 64'(e_msg));
        check("done",     64'(done),     64'(m_phase == 3));
        check("busy",     64'(busy),     64'((m_phase != 0) || (exp_q.size() != 0)));
        check("err",      64'(err),      64'(m_err));
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    // One cycle: at the falling edge, check the outputs, then drive the inputs
    // for the next rising edge. When eg is set, the crossbar echoes the
    // expected word while a reply is awaited; otherwise the echo is stuck at 0.
    task automatic cycle(input logic rv, input logic [MW-1:0] msg, input logic cr,
                         input logic ec, input logic eg);
        @(negedge clk);
        check_outputs();
        req_val  = rv;
        req_msg  = msg;
        ctrl_rdy = cr;
        err_clr  = ec;
        echo_msg = (eg && m_phase == 2) ? m_word : '0;
    endtask

    // Assert reset in the middle of a cycle, check that the outputs clear
    // at once, then release on the next falling edge.
    task automatic apply_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_ctrl_val", 64'(ctrl_val), 64'(0));
        check("rst_ctrl_msg", 64'(ctrl_msg), 64'(0));
        check("rst_busy",     64'(busy),     64'(0));
        check("rst_req_rdy",  64'(req_rdy),  64'(0));
        check("rst_done",     64'(done),     64'(0));
        req_val  = 1'b0;
        ctrl_rdy = 1'b0;
        err_clr  = 1'b0;
        echo_msg = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        req_val  = 1'b0;
        req_msg  = '0;
        ctrl_rdy = 1'b0;
        err_clr  = 1'b0;
        echo_msg = '0;

        // Reset state while reset is held.
        repeat (2) cycle(1'b1, 6'h15, 1'b1, 1'b0, 1'b1);
        check("rst_hold_req_rdy", 64'(req_rdy), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        // Single request: the word appears the cycle after it is enqueued.
        cycle(1'b1, 6'h0A, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 6'h00, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 6'h00, 1'b1, 1'b0, 1'b1);
        check("t1_ctrl_val", 64'(ctrl_val), 64'(1));
        check("t1_ctrl_msg", 64'(ctrl_msg), 64'(42'h0B0_0000_0000));
        cycle(1'b0, 6'h00, 1'b1, 1'b0, 1'b1);
`ifdef XBAR_ISSUER_ECHO_CHECK_EN
        cycle(1'b0, 6'h00, 1'b1, 1'b0, 1'b1);
`endif
        check("t1_done", 64'(done), 64'(1));
        check("t1_err",  64'(err),  64'(0));
        repeat (3) cycle(1'b0, 6'h00, 1'b1, 1'b0, 1'b1);

        // ctrl_rdy withheld: the word must be held stable.
        cycle(1'b1, MW'($urandom), 1'b0, 1'b0, 1'b1);
        repeat (7) cycle(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
        repeat (6) cycle(1'b0, 6'h00, 1'b1, 1'b0, 1'b1);

        // Fill the FIFO while the crossbar stalls, then drain it in order.
        repeat (5) cycle(1'b1, MW'($urandom), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, MW'($urandom), 1'b0, 1'b0, 1'b1);
        check("t3_full_req_rdy", 64'(req_rdy), 64'(0));
        repeat (3) cycle(1'b1, MW'($urandom), 1'b0, 1'b0, 1'b1);
        repeat (40) cycle(1'b0, 6'h00, 1'b1, 1'b0, 1'b1);

`ifdef XBAR_ISSUER_ECHO_CHECK_EN
        // Echo never returns: resends, then err and done; err_clr clears err.
        cycle(1'b1, 6'h2D, 1'b1, 1'b0, 1'b0);
        repeat (40) cycle(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
        check("t5_err_set", 64'(err), 64'(1));
        cycle(1'b0, 6'h00, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 6'h00, 1'b1, 1'b0, 1'b0);
        check("t5_err_clr", 64'(err), 64'(0));
`endif

        // Reset while sending with two entries queued.
        repeat (3) cycle(1'b1, MW'($urandom), 1'b0, 1'b0, 1'b1);
        apply_reset();
        cycle(1'b0, 6'h00, 1'b1, 1'b0, 1'b1);
        check("t6_busy_after", 64'(busy), 64'(0));
        repeat (4) cycle(1'b0, 6'h00, 1'b1, 1'b0, 1'b1);

        // Random traffic in blocks, each followed by a reset.
        for (int blk = 0; blk < 3; blk++) begin
            repeat (1000) begin
                cycle(1'($urandom_range(0, 99) < 50), MW'($urandom),
                      1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 5),
                      1'($urandom_range(0, 99) < 85));
            end
            apply_reset();
        end
        repeat (3) cycle(1'b0, 6'h00, 1'b1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
